output_layer_scheduler: RTL and testbench
=========================================

// Module: output_layer_scheduler
// PURPOSE
//  Frame-level controller in front of output_layer. Accepts one spike frame from the upstream layer,
//  launches output_layer, collects its logits, and runs a sequential argmax. Presents the class
//  index plus logits downstream on a valid/ready handshake. One frame is in flight at a time; it
//  also counts completed frames.
// PARAMETERS
//  INPUT_SIZE         128  spikes per frame
//  INPUT_DATA_WIDTH   8    bits per spike value (signed)
//  OUTPUT_SIZE        3    logits/classes per frame
//  OUTPUT_DATA_WIDTH  16   bits per logit (signed)
//  FRAME_CNT_WIDTH    16   width of completed-frame counter
//  TIMEOUT_CYCLES     1024 WAIT-state watchdog limit (used only with SCHED_TIMEOUT_EN)
//  CLASS_WIDTH        localparam = (OUTPUT_SIZE>1) ? $clog2(OUTPUT_SIZE) : 1
// PORTS
//  clk        in   1                       single clock, rising edge
//  rst_n      in   1                       asynchronous active-low reset
//  s_valid    in   1                       upstream frame valid
//  s_ready    out  1                       scheduler can accept a frame
//  s_spikes   in   INPUT_SIZE*INPUT_DATA_WIDTH    upstream frame
//  l_valid    out  1                       to output_layer i_valid
//  l_ready    in   1                       from output_layer i_ready
//  l_spikes   out  INPUT_SIZE*INPUT_DATA_WIDTH    to output_layer i_spikes (registered frame)
//  l_o_valid  in   1                       from output_layer o_valid
//  l_o_ready  out  1                       to output_layer o_ready
//  l_logits   in   OUTPUT_SIZE*OUTPUT_DATA_WIDTH  from output_layer o_logits
//  m_valid    out  1                       result valid
//  m_ready    in   1                       downstream accepts result
//  m_class    out  CLASS_WIDTH             argmax index
//  m_max      out  OUTPUT_DATA_WIDTH       logit value at m_class
//  m_logits   out  OUTPUT_SIZE*OUTPUT_DATA_WIDTH  captured logits
//  frame_cnt  out  FRAME_CNT_WIDTH         completed frames (increments on m handshake, wraps)
//  m_error    out  1                       [SCHED_TIMEOUT_EN only] result is a timeout, not valid data
// BEHAVIOUR
//  Reset: state=IDLE. All registered outputs 0: l_valid, m_valid, m_class, m_max, m_logits,
//   frame_cnt, l_spikes, m_error. Asserting reset mid-frame aborts it; nothing is replayed.
//  s_ready=(state==IDLE). l_o_ready=(state==WAIT || state==IDLE); in IDLE this drains stale
//   results, which are discarded.
//  FSM:
//   IDLE   : s_valid -> capture s_spikes into l_spikes -> LAUNCH.
//   LAUNCH : l_valid=1, l_spikes stable. l_valid&&l_ready -> WAIT (l_valid drops next cycle).
//   WAIT   : l_o_valid -> capture l_logits into m_logits, idx=0 -> ARGMAX.
//   ARGMAX : one logit per cycle, idx 0..OUTPUT_SIZE-1. idx 0 loads max/class.
//            Later entries replace only if strictly greater (signed compare), so ties go to the
//            lowest index. After idx==OUTPUT_SIZE-1 -> OUT.
//   OUT    : m_valid=1; m_class/m_max/m_logits held stable until m_ready.
//            On handshake: frame_cnt+1 (wraps to 0 at all-ones) -> IDLE.
//  No bypass: the earliest next-frame accept is 1 cycle after the m handshake.
//   s_valid is ignored outside IDLE.
//  Latency: s accept -> m_valid = 1 (LAUNCH min) + output_layer latency + 1 (capture) + OUTPUT_SIZE.
//  m_max is full OUTPUT_DATA_WIDTH signed. No arithmetic is done beyond compare.
// CONFIGURATION
//  `SCHED_TIMEOUT_EN defined: WAIT counts cycles.
//   If TIMEOUT_CYCLES elapse without l_o_valid: m_logits=0, m_class=0, m_max=0, m_error=1 -> OUT
//   (ARGMAX skipped). frame_cnt still increments on the handshake.
//   m_error clears on the next s accept. A late l_o_valid is drained in IDLE.
//  Not defined: no counter, no m_error port; WAIT waits indefinitely.
// STRUCTURE
//  Package snn_ctrl_pkg (header include): FSM state encodings
//   (IDLE=0, LAUNCH=1, WAIT=2, ARGMAX=3, OUT=4), 3-bit state width, CLASS_WIDTH function.
//  One sub-module: argmax_seq (start, OUTPUT_SIZE-wide logit vector in, done, class, max out).
//   The scheduler FSM owns handshakes and the frame counter.
// TESTING
//  1 Logits {2:+5, 1:-3, 0:+100} -> m_class=0, m_max=100, frame_cnt 0->1 after m_ready.
//  2 Tie {2:+7, 1:+7, 0:-1} -> m_class=1 (lowest index of max); all-negative
//    {-9,-2,-5} (idx2..0) -> m_class=1, m_max=-2.
//  3 m_ready held low 20 cycles in OUT -> m_valid and outputs stable,
//    s_ready=0, a new s_valid is not accepted.
//  4 l_ready low 5 cycles in LAUNCH -> l_valid held, l_spikes unchanged,
//    WAIT entered the cycle after l_ready rises.
//  5 rst_n pulsed low during ARGMAX -> all outputs 0 asynchronously, IDLE, s_ready=1 after release.
//  6 [SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16] l_o_valid never asserted -> m_valid with m_error=1
//    after 16 WAIT cycles; a late l_o_valid is drained and the next frame is correct.

Source files
------------

// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the SNN frame controllers: scheduler state
// encodings and the class-index width helper.
package snn_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_OUT    = 3'd4
  } sched_state_e;

  // Width of a class index; a single class still needs one bit.
  function automatic int class_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_layer_scheduler_argmax.sv
// argmax_seq: sequential signed argmax over a packed logit vector.
// One entry is examined per cycle starting from index 0. The result for the
// entry being examined is presented combinationally together with done_o,
// so the caller can register the final class/max on the last step.
// Ties keep the earlier (lower) index because only a strictly greater value
// replaces the running maximum.
module argmax_seq
  import snn_ctrl_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 16,
  parameter int CW = class_width(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [N*W-1:0]      logits_i,
  output logic                done_o,
  output logic [CW-1:0]       class_o,
  output logic signed [W-1:0] max_o
);

  logic                busy_q;
  logic [CW-1:0]       idx_q;
  logic [CW-1:0]       class_q;
  logic signed [W-1:0] max_q;
  logic signed [W-1:0] cur;
  logic                take;

  // Compare the current entry against the running maximum.
  always_comb begin
    cur     = $signed(logits_i[idx_q*W +: W]);
    take    = (idx_q == '0) || (cur > max_q);
    class_o = take ? idx_q : class_q;
    max_o   = take ? cur : max_q;
    done_o  = busy_q && (idx_q == CW'(N-1));
  end

  // Walk the index and keep the running best entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      idx_q   <= '0;
      class_q <= '0;
      max_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
    end else if (busy_q) begin
      class_q <= class_o;
      max_q   <= max_o;
      if (idx_q == CW'(N-1)) begin
        busy_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_layer_scheduler.sv
// output_layer_scheduler: frame-level controller in front of output_layer.
// Takes one spike frame, launches output_layer, captures its logits, runs a
// sequential argmax and presents class/max/logits on a valid/ready port.
// Optional macro SCHED_TIMEOUT_EN adds a WAIT watchdog and the m_error port.
//
//   state  | meaning
//   IDLE   | ready for a frame; stale output_layer results are drained
//   LAUNCH | l_valid high with the registered frame, waiting for l_ready
//   WAIT   | waiting for output_layer logits (optional watchdog runs)
//   ARGMAX | one logit examined per cycle by argmax_seq
//   OUT    | result held on m_* until m_ready
module output_layer_scheduler
  import snn_ctrl_pkg::*;
#(
  parameter  int INPUT_SIZE        = 128,
  parameter  int INPUT_DATA_WIDTH  = 8,
  parameter  int OUTPUT_SIZE       = 3,
  parameter  int OUTPUT_DATA_WIDTH = 16,
  parameter  int FRAME_CNT_WIDTH   = 16,
  parameter  int TIMEOUT_CYCLES    = 1024,
  localparam int CLASS_WIDTH       = class_width(OUTPUT_SIZE)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [INPUT_SIZE*INPUT_DATA_WIDTH-1:0]   s_spikes,
  output logic                                     l_valid,
  input  logic                                     l_ready,
  output logic [INPUT_SIZE*INPUT_DATA_WIDTH-1:0]   l_spikes,
  input  logic                                     l_o_valid,
  output logic                                     l_o_ready,
  input  logic [OUTPUT_SIZE*OUTPUT_DATA_WIDTH-1:0] l_logits,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [CLASS_WIDTH-1:0]                   m_class,
  output logic [OUTPUT_DATA_WIDTH-1:0]             m_max,
  output logic [OUTPUT_SIZE*OUTPUT_DATA_WIDTH-1:0] m_logits,
`ifdef SCHED_TIMEOUT_EN
  output logic                                     m_error,
`endif
  output logic [FRAME_CNT_WIDTH-1:0]               frame_cnt
);

  sched_state_e                              state_q;
  logic                                      l_valid_q;
  logic [INPUT_SIZE*INPUT_DATA_WIDTH-1:0]    l_spikes_q;
  logic                                      m_valid_q;
  logic [CLASS_WIDTH-1:0]                    m_class_q;
  logic [OUTPUT_DATA_WIDTH-1:0]              m_max_q;
  logic [OUTPUT_SIZE*OUTPUT_DATA_WIDTH-1:0]  m_logits_q;
  logic [FRAME_CNT_WIDTH-1:0]                frame_cnt_q;
  logic [FRAME_CNT_WIDTH-1:0]                frame_cnt_d;

  logic                                      arg_start;
  logic                                      arg_done;
  logic [CLASS_WIDTH-1:0]                    arg_class;
  logic signed [OUTPUT_DATA_WIDTH-1:0]       arg_max;

`ifdef SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             m_error_q;
  assign m_error = m_error_q;
`endif

  assign s_ready   = (state_q == ST_IDLE);
  assign l_o_ready = (state_q == ST_WAIT) || (state_q == ST_IDLE);
  assign l_valid   = l_valid_q;
  assign l_spikes  = l_spikes_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign m_max     = m_max_q;
  assign m_logits  = m_logits_q;
  assign frame_cnt = frame_cnt_q;

  // Argmax starts on the same edge the logits are captured; it reads the
  // captured copy, which stays put until the next frame.
  assign arg_start   = (state_q == ST_WAIT) && l_o_valid;
  assign frame_cnt_d = frame_cnt_q + 1'b1;

  argmax_seq #(
    .N  (OUTPUT_SIZE),
    .W  (OUTPUT_DATA_WIDTH),
    .CW (CLASS_WIDTH)
  ) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (arg_start),
    .logits_i (m_logits_q),
    .done_o   (arg_done),
    .class_o  (arg_class),
    .max_o    (arg_max)
  );

  // Frame sequencing, handshakes, result registers and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      l_valid_q   <= 1'b0;
      l_spikes_q  <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      m_max_q     <= '0;
      m_logits_q  <= '0;
      frame_cnt_q <= '0;
`ifdef SCHED_TIMEOUT_EN
      tmo_q       <= '0;
      m_error_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            l_spikes_q <= s_spikes;
            l_valid_q  <= 1'b1;
            state_q    <= ST_LAUNCH;
`ifdef SCHED_TIMEOUT_EN
            m_error_q  <= 1'b0;
`endif
          end
        end
        ST_LAUNCH: begin
          if (l_ready) begin
            l_valid_q <= 1'b0;
            state_q   <= ST_WAIT;
`ifdef SCHED_TIMEOUT_EN
            tmo_q     <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        ST_WAIT: begin
          if (l_o_valid) begin
            m_logits_q <= l_logits;
            state_q    <= ST_ARGMAX;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (tmo_q == '0) begin
            // Watchdog expired: report an error result instead of logits.
            m_logits_q <= '0;
            m_class_q  <= '0;
            m_max_q    <= '0;
            m_error_q  <= 1'b1;
            m_valid_q  <= 1'b1;
            state_q    <= ST_OUT;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
`endif
        end
        ST_ARGMAX: begin
          if (arg_done) begin
            m_class_q <= arg_class;
            m_max_q   <= arg_max;
            m_valid_q <= 1'b1;
            state_q   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_q   <= 1'b0;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_scheduler.sv
// Directed bench for output_layer_scheduler; the output_layer side is
// driven directly by the stimulus tasks.
module tb_output_layer_scheduler;

  localparam int IS  = 128;
  localparam int IW  = 8;
  localparam int OS  = 3;
  localparam int OW  = 16;
  localparam int FW  = 16;
  localparam int TMO = 16;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [IS*IW-1:0]  s_spikes;
  logic              l_valid;
  logic              l_ready;
  logic [IS*IW-1:0]  l_spikes;
  logic              l_o_valid;
  logic              l_o_ready;
  logic [OS*OW-1:0]  l_logits;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        m_class;
  logic [OW-1:0]     m_max;
  logic [OS*OW-1:0]  m_logits;
  logic [FW-1:0]     frame_cnt;
`ifdef SCHED_TIMEOUT_EN
  logic              m_error;
`endif

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_cnt = '0;

  output_layer_scheduler #(
    .INPUT_SIZE        (IS),
    .INPUT_DATA_WIDTH  (IW),
    .OUTPUT_SIZE       (OS),
    .OUTPUT_DATA_WIDTH (OW),
    .FRAME_CNT_WIDTH   (FW),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_spikes  (s_spikes),
    .l_valid   (l_valid),
    .l_ready   (l_ready),
    .l_spikes  (l_spikes),
    .l_o_valid (l_o_valid),
    .l_o_ready (l_o_ready),
    .l_logits  (l_logits),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_class   (m_class),
    .m_max     (m_max),
    .m_logits  (m_logits),
`ifdef SCHED_TIMEOUT_EN
    .m_error   (m_error),
`endif
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OS*OW-1:0] pack3(input int v2, input int v1, input int v0);
    logic [OW-1:0] a, b, c;
    a = v2[OW-1:0];
    b = v1[OW-1:0];
    c = v0[OW-1:0];
    return {a, b, c};
  endfunction

  function automatic logic [IS*IW-1:0] mk_spikes(input int seed);
    logic [IS*IW-1:0] r;
    for (int i = 0; i < IS; i++) r[i*IW +: IW] = IW'(seed * 7 + i * 3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a frame, launch immediately, return logits one cycle into WAIT,
  // then wait (bounded) for m_valid. lat counts edges after the capture edge.
  task automatic run_frame(input logic [IS*IW-1:0] spk, input logic [OS*OW-1:0] lg,
                           output bit ok, output int lat);
    s_spikes = spk;
    s_valid  = 1'b1;
    tick();
    s_valid  = 1'b0;
    l_ready  = 1'b1;
    tick();
    l_ready   = 1'b0;
    l_logits  = lg;
    l_o_valid = 1'b1;
    tick();
    l_o_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 50) begin
      tick();
      lat++;
    end
    ok = m_valid;
  endtask

  task automatic do_handshake();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0h exp 0", m_valid); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL reset_l_valid got %0h exp 0", l_valid); end
    checks++; if (m_class !== 2'd0) begin errors++; $display("FAIL reset_m_class got %0h exp 0", m_class); end
    checks++; if (m_max !== 16'd0) begin errors++; $display("FAIL reset_m_max got %0h exp 0", m_max); end
    checks++; if (m_logits !== '0) begin errors++; $display("FAIL reset_m_logits got %0h exp 0", m_logits); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0h exp 0", frame_cnt); end
    checks++; if (l_spikes !== '0) begin errors++; $display("FAIL reset_l_spikes nonzero"); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0h exp 1", s_ready); end
    checks++; if (l_o_ready !== 1'b1) begin errors++; $display("FAIL reset_l_o_ready got %0h exp 1", l_o_ready); end
`ifdef SCHED_TIMEOUT_EN
    checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL reset_m_error got %0h exp 0", m_error); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_argmax_basic();
    bit ok; int lat;
    run_frame(mk_spikes(1), pack3(5, -3, 100), ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_m_valid timeout got %0d exp 1", ok); end
    checks++; if (lat !== OS) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, OS); end
    checks++; if (m_class !== 2'd0) begin errors++; $display("FAIL basic_class got %0d exp 0", m_class); end
    checks++; if (m_max !== 16'd100) begin errors++; $display("FAIL basic_max got %0h exp 0064", m_max); end
    checks++; if (m_logits !== pack3(5, -3, 100)) begin errors++; $display("FAIL basic_logits got %0h", m_logits); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_out got %0h exp 0", s_ready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnt_before got %0d exp 0", frame_cnt); end
    do_handshake();
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL basic_cnt_after got %0d exp %0d", frame_cnt, exp_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_m_valid_drop got %0h exp 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready_idle got %0h exp 1", s_ready); end
  endtask

  task automatic test_ties_and_negative();
    bit ok; int lat;
    run_frame(mk_spikes(2), pack3(7, 7, -1), ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tie_m_valid timeout got %0d exp 1", ok); end
    checks++; if (m_class !== 2'd1) begin errors++; $display("FAIL tie_class got %0d exp 1", m_class); end
    checks++; if (m_max !== 16'd7) begin errors++; $display("FAIL tie_max got %0h exp 0007", m_max); end
    do_handshake();
    run_frame(mk_spikes(3), pack3(-9, -2, -5), ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL neg_m_valid timeout got %0d exp 1", ok); end
    checks++; if (m_class !== 2'd1) begin errors++; $display("FAIL neg_class got %0d exp 1", m_class); end
    checks++; if (m_max !== 16'hFFFE) begin errors++; $display("FAIL neg_max got %0h exp fffe", m_max); end
    do_handshake();
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL neg_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_out_stall();
    bit ok; int lat;
    run_frame(mk_spikes(4), pack3(40, -7, 40), ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_m_valid timeout got %0d exp 1", ok); end
    s_spikes = mk_spikes(99);
    s_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid cyc %0d got %0h exp 1", i, m_valid); end
      checks++; if (m_class !== 2'd0) begin errors++; $display("FAIL stall_class cyc %0d got %0d exp 0", i, m_class); end
      checks++; if (m_max !== 16'd40) begin errors++; $display("FAIL stall_max cyc %0d got %0h exp 0028", i, m_max); end
      checks++; if (m_logits !== pack3(40, -7, 40)) begin errors++; $display("FAIL stall_logits cyc %0d got %0h", i, m_logits); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready cyc %0d got %0h exp 0", i, s_ready); end
      checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL stall_accepted cyc %0d l_valid got %0h exp 0", i, l_valid); end
      checks++; if (l_spikes !== mk_spikes(4)) begin errors++; $display("FAIL stall_l_spikes cyc %0d changed", i); end
    end
    s_valid = 1'b0;
    do_handshake();
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
    tick();
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL stall_no_replay l_valid got %0h exp 0", l_valid); end
  endtask

  task automatic test_launch_stall();
    int lat;
    s_spikes = mk_spikes(7);
    s_valid  = 1'b1;
    tick();
    s_valid  = 1'b0;
    s_spikes = mk_spikes(8);
    l_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (l_valid !== 1'b1) begin errors++; $display("FAIL launch_l_valid cyc %0d got %0h exp 1", i, l_valid); end
      checks++; if (l_spikes !== mk_spikes(7)) begin errors++; $display("FAIL launch_l_spikes cyc %0d changed", i); end
      checks++; if (l_o_ready !== 1'b0) begin errors++; $display("FAIL launch_l_o_ready cyc %0d got %0h exp 0", i, l_o_ready); end
      tick();
    end
    l_ready = 1'b1;
    tick();
    l_ready = 1'b0;
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL launch_l_valid_drop got %0h exp 0", l_valid); end
    checks++; if (l_o_ready !== 1'b1) begin errors++; $display("FAIL launch_wait_l_o_ready got %0h exp 1", l_o_ready); end
    l_logits  = pack3(9, 2, 3);
    l_o_valid = 1'b1;
    tick();
    l_o_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 50) begin tick(); lat++; end
    checks++; if (lat !== OS) begin errors++; $display("FAIL launch_latency got %0d exp %0d", lat, OS); end
    checks++; if (m_class !== 2'd2) begin errors++; $display("FAIL launch_class got %0d exp 2", m_class); end
    checks++; if (m_max !== 16'd9) begin errors++; $display("FAIL launch_max got %0h exp 0009", m_max); end
    do_handshake();
  endtask

  task automatic test_drain();
    l_logits  = pack3(100, 100, 100);
    l_o_valid = 1'b1;
    checks++; if (l_o_ready !== 1'b1) begin errors++; $display("FAIL drain_l_o_ready got %0h exp 1", l_o_ready); end
    tick();
    tick();
    l_o_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_m_valid cyc %0d got %0h exp 0", i, m_valid); end
    end
    checks++; if (m_logits !== pack3(9, 2, 3)) begin errors++; $display("FAIL drain_logits got %0h", m_logits); end
    checks++; if (m_class !== 2'd2) begin errors++; $display("FAIL drain_class got %0d exp 2", m_class); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int lat;
    s_spikes = mk_spikes(11);
    s_valid  = 1'b1;
    tick();
    s_valid  = 1'b0;
    l_ready  = 1'b1;
    tick();
    l_ready   = 1'b0;
    l_logits  = pack3(1, 20, 3);
    l_o_valid = 1'b1;
    tick();
    l_o_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid got %0h exp 0", m_valid); end
    checks++; if (l_valid !== 1'b0) begin errors++; $display("FAIL rstmid_l_valid got %0h exp 0", l_valid); end
    checks++; if (m_class !== 2'd0) begin errors++; $display("FAIL rstmid_class got %0d exp 0", m_class); end
    checks++; if (m_max !== 16'd0) begin errors++; $display("FAIL rstmid_max got %0h exp 0", m_max); end
    checks++; if (m_logits !== '0) begin errors++; $display("FAIL rstmid_logits got %0h exp 0", m_logits); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", frame_cnt); end
    checks++; if (l_spikes !== '0) begin errors++; $display("FAIL rstmid_l_spikes nonzero"); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready got %0h exp 1", s_ready); end
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_replay cyc %0d m_valid got %0h exp 0", i, m_valid); end
    end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready_after got %0h exp 1", s_ready); end
    run_frame(mk_spikes(12), pack3(-1, -1, -1), ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_frame timeout got %0d exp 1", ok); end
    checks++; if (m_class !== 2'd0) begin errors++; $display("FAIL rstmid_frame_class got %0d exp 0", m_class); end
    checks++; if (m_max !== 16'hFFFF) begin errors++; $display("FAIL rstmid_frame_max got %0h exp ffff", m_max); end
    do_handshake();
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL rstmid_frame_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int lat;
    s_spikes = mk_spikes(5);
    s_valid  = 1'b1;
    tick();
    s_valid  = 1'b0;
    l_ready  = 1'b1;
    tick();
    l_ready = 1'b0;
    lat = 0;
    while (!m_valid && lat < 100) begin tick(); lat++; end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL tmo_m_valid got %0h exp 1", m_valid); end
    checks++; if (lat !== TMO) begin errors++; $display("FAIL tmo_cycles got %0d exp %0d", lat, TMO); end
    checks++; if (m_error !== 1'b1) begin errors++; $display("FAIL tmo_m_error got %0h exp 1", m_error); end
    checks++; if (m_class !== 2'd0) begin errors++; $display("FAIL tmo_class got %0d exp 0", m_class); end
    checks++; if (m_max !== 16'd0) begin errors++; $display("FAIL tmo_max got %0h exp 0", m_max); end
    checks++; if (m_logits !== '0) begin errors++; $display("FAIL tmo_logits got %0h exp 0", m_logits); end
    do_handshake();
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL tmo_cnt got %0d exp %0d", frame_cnt, exp_cnt); end
    checks++; if (m_error !== 1'b1) begin errors++; $display("FAIL tmo_err_hold got %0h exp 1", m_error); end
    l_logits  = pack3(7, 7, 7);
    l_o_valid = 1'b1;
    tick();
    l_o_valid = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL tmo_late_drain m_valid got %0h exp 0", m_valid); end
    run_frame(mk_spikes(6), pack3(2, 8, -4), ok, lat);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_next timeout got %0d exp 1", ok); end
    checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL tmo_next_err got %0h exp 0", m_error); end
    checks++; if (m_class !== 2'd1) begin errors++; $display("FAIL tmo_next_class got %0d exp 1", m_class); end
    checks++; if (m_max !== 16'd8) begin errors++; $display("FAIL tmo_next_max got %0h exp 0008", m_max); end
    do_handshake();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_spikes  = '0;
    l_ready   = 1'b0;
    l_o_valid = 1'b0;
    l_logits  = '0;
    m_ready   = 1'b0;
    test_reset();
    test_argmax_basic();
    test_ties_and_negative();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_out_stall();
    test_launch_stall();
    test_drain();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
